// File: rtl/seq_add_sub_pkg.sv
// Shared types and helpers for the chunked sequential adder/subtractor.
package seq_add_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int num_chunks(input int w, input int chunk);
      return w / chunk;
   endfunction

endpackage

// File: rtl/seq_add_sub_chunk_adder.sv
// Combinational CHUNK-bit adder slice with carry into its top bit exposed.
module chunk_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb_in
);

   logic [CHUNK:0] full;

   assign full = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
   assign sum  = full[CHUNK-1:0];
   assign cout = full[CHUNK];
   // Top-bit sum is x^y^cin, so cin of that bit falls out of the sum.
   assign c_msb_in = sum[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];

endmodule

// File: rtl/seq_add_sub.sv
// Multi-cycle W-bit adder/subtractor, CHUNK bits per clock, with flags.
module seq_add_sub
   import seq_add_sub_pkg::*;
#(
   parameter int W     = 8,
   parameter int CHUNK = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] s,
   output logic         c,
   output logic         v,
   output logic         z
);

   localparam int N  = num_chunks(W, CHUNK);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   if (W < 2) begin : g_bad_w
      $error("seq_add_sub: W must be at least 2");
   end
   if (CHUNK < 1 || (W % CHUNK) != 0) begin : g_bad_chunk
      $error("seq_add_sub: W must be a multiple of CHUNK");
   end

   state_e         state_q;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [W-1:0]   r_q;
   logic [W-1:0]   r_d;
   logic [W-1:0]   s_q;
   logic [IW-1:0]  idx_q;
   logic           cy_q;
   logic           c_q;
   logic           v_q;
   logic           z_q;
   logic           ov_q;

   logic [CHUNK-1:0] x_w;
   logic [CHUNK-1:0] y_w;
   logic [CHUNK-1:0] sum_w;
   logic             cout_w;
   logic             cmsb_w;
   logic             last_w;
   logic             acc_w;

   assign in_ready = (state_q == IDLE) ||
                     ((state_q == DONE) && out_ready);
   assign acc_w    = in_valid && in_ready;
   assign last_w   = (idx_q == IW'(N - 1));

   assign x_w = a_q[int'(idx_q) * CHUNK +: CHUNK];
   assign y_w = b_q[int'(idx_q) * CHUNK +: CHUNK];

   chunk_adder #(
      .CHUNK(CHUNK)
   ) u_chunk (
      .x       (x_w),
      .y       (y_w),
      .cin     (cy_q),
      .sum     (sum_w),
      .cout    (cout_w),
      .c_msb_in(cmsb_w)
   );

   always_comb begin
      r_d = r_q;
      r_d[int'(idx_q) * CHUNK +: CHUNK] = sum_w;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         s_q     <= '0;
         idx_q   <= '0;
         cy_q    <= 1'b0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         z_q     <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: ;
            RUN: begin
               r_q   <= r_d;
               cy_q  <= cout_w;
               idx_q <= idx_q + IW'(1);
               if (last_w) begin
                  s_q     <= r_d;
                  c_q     <= cout_w;
                  v_q     <= cmsb_w ^ cout_w;
                  z_q     <= (r_d == '0);
                  ov_q    <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  ov_q    <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
         // Accept overrides the DONE->IDLE move for back-to-back traffic.
         if (acc_w) begin
            a_q     <= a;
            b_q     <= b ^ {W{sub}};
            cy_q    <= sub;
            idx_q   <= '0;
            state_q <= RUN;
         end
      end
   end

   assign out_valid = ov_q;
   assign s         = s_q;
   assign c         = c_q;
   assign v         = v_q;
   assign z         = z_q;

endmodule

// File: tb/tb_seq_add_sub.sv
// Directed bench over five W/CHUNK configurations of seq_add_sub.
module tb_seq_add_sub;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] iv;
   logic [4:0] ordy;
   logic [7:0] a;
   logic [7:0] b;
   logic       sb;

   logic [4:0] ov;
   logic [4:0] ir;
   logic [4:0] cc;
   logic [4:0] vv;
   logic [4:0] zz;
   logic [3:0] s0;
   logic [7:0] s1;
   logic [7:0] s2;
   logic [7:0] s3;
   logic [7:0] s4;

   int ncmp = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   seq_add_sub #(.W(4), .CHUNK(2)) u0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
      .a(a[3:0]), .b(b[3:0]), .sub(sb), .out_valid(ov[0]),
      .out_ready(ordy[0]), .s(s0), .c(cc[0]), .v(vv[0]), .z(zz[0]));

   seq_add_sub #(.W(8), .CHUNK(4)) u1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
      .a(a), .b(b), .sub(sb), .out_valid(ov[1]),
      .out_ready(ordy[1]), .s(s1), .c(cc[1]), .v(vv[1]), .z(zz[1]));

   seq_add_sub #(.W(8), .CHUNK(2)) u2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
      .a(a), .b(b), .sub(sb), .out_valid(ov[2]),
      .out_ready(ordy[2]), .s(s2), .c(cc[2]), .v(vv[2]), .z(zz[2]));

   seq_add_sub #(.W(8), .CHUNK(8)) u3 (
      .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]),
      .a(a), .b(b), .sub(sb), .out_valid(ov[3]),
      .out_ready(ordy[3]), .s(s3), .c(cc[3]), .v(vv[3]), .z(zz[3]));

   seq_add_sub #(.W(8), .CHUNK(1)) u4 (
      .clk(clk), .rst(rst), .in_valid(iv[4]), .in_ready(ir[4]),
      .a(a), .b(b), .sub(sb), .out_valid(ov[4]),
      .out_ready(ordy[4]), .s(s4), .c(cc[4]), .v(vv[4]), .z(zz[4]));

   function automatic logic [7:0] s_of(input int u);
      case (u)
         0:       return {4'h0, s0};
         1:       return s1;
         2:       return s2;
         3:       return s3;
         default: return s4;
      endcase
   endfunction

   task automatic chk8(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_res(input string tag, input int u,
                          input logic [7:0] es, input logic ec,
                          input logic ev, input logic ez);
      chk1({tag, ".ov"}, ov[u], 1'b1);
      chk8({tag, ".s"}, s_of(u), es);
      chk1({tag, ".c"}, cc[u], ec);
      chk1({tag, ".v"}, vv[u], ev);
      chk1({tag, ".z"}, zz[u], ez);
   endtask

   // Offer one operation to unit u and check N-edge latency and flags.
   task automatic op(input string tag, input int u, input int n,
                     input logic [7:0] aa, input logic [7:0] bb,
                     input logic sub_i, input logic [7:0] es,
                     input logic ec, input logic ev, input logic ez,
                     input logic consume);
      @(negedge clk);
      chk1({tag, ".in_ready"}, ir[u], 1'b1);
      a = aa;
      b = bb;
      sb = sub_i;
      iv[u] = 1'b1;
      @(posedge clk);
      #1 iv[u] = 1'b0;
      chk1({tag, ".ov_accept"}, ov[u], 1'b0);
      for (int e = 1; e <= n; e++) begin
         @(posedge clk);
         #1;
         if (e < n) chk1({tag, ".ov_early"}, ov[u], 1'b0);
         else chk_res(tag, u, es, ec, ev, ez);
      end
      if (consume) begin
         @(negedge clk);
         ordy[u] = 1'b1;
         @(posedge clk);
         #1 ordy[u] = 1'b0;
         chk1({tag, ".ov_drop"}, ov[u], 1'b0);
         chk1({tag, ".idle_rdy"}, ir[u], 1'b1);
         chk8({tag, ".s_keep"}, s_of(u), es);
      end
   endtask

   initial begin
      rst = 1'b1;
      iv = '0;
      ordy = '0;
      a = '0;
      b = '0;
      sb = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int u = 0; u < 5; u++) begin
         chk1("rst.ov", ov[u], 1'b0);
         chk1("rst.in_ready", ir[u], 1'b1);
         chk8("rst.s", s_of(u), 8'd0);
         chk1("rst.c", cc[u], 1'b0);
         chk1("rst.v", vv[u], 1'b0);
         chk1("rst.z", zz[u], 1'b0);
      end

      op("w4_6p6", 0, 2, 8'd6, 8'd6, 1'b0, 8'd12, 1'b0, 1'b1, 1'b0, 1'b1);
      op("w4_8m6", 0, 2, 8'd8, 8'd6, 1'b1, 8'd2, 1'b1, 1'b1, 1'b0, 1'b1);
      op("w4_10m6", 0, 2, 8'd10, 8'd6, 1'b1, 8'd4, 1'b1, 1'b1, 1'b0, 1'b1);
      op("w4_10m8", 0, 2, 8'd10, 8'd8, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0, 1'b1);
      op("w8_6m6", 1, 2, 8'd6, 8'd6, 1'b1, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1);

      // Backpressure: hold result for 5 cycles, then back-to-back accept.
      op("w8_5m9", 1, 2, 8'd5, 8'd9, 1'b1, 8'd252, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (5) begin
         @(posedge clk);
         #1;
         chk_res("bp_hold", 1, 8'd252, 1'b0, 1'b0, 1'b0);
         chk1("bp_hold.in_ready", ir[1], 1'b0);
      end
      @(negedge clk);
      ordy[1] = 1'b1;
      a = 8'd6;
      b = 8'd6;
      sb = 1'b1;
      iv[1] = 1'b1;
      #1 chk1("b2b.in_ready", ir[1], 1'b1);
      @(posedge clk);
      #1;
      iv[1] = 1'b0;
      ordy[1] = 1'b0;
      chk1("b2b.ov_run", ov[1], 1'b0);
      chk1("b2b.rdy_run", ir[1], 1'b0);
      chk8("b2b.s_old", s1, 8'd252);
      @(posedge clk);
      #1 chk1("b2b.ov_early", ov[1], 1'b0);
      @(posedge clk);
      #1 chk_res("b2b", 1, 8'd0, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      ordy[1] = 1'b1;
      @(posedge clk);
      #1 ordy[1] = 1'b0;
      chk1("b2b.ov_drop", ov[1], 1'b0);

      op("n1_200p100", 3, 1, 8'd200, 8'd100, 1'b0, 8'd44, 1'b1, 1'b0,
         1'b0, 1'b1);
      op("n8_200p100", 4, 8, 8'd200, 8'd100, 1'b0, 8'd44, 1'b1, 1'b0,
         1'b0, 1'b1);
      op("c2_200p100", 2, 4, 8'd200, 8'd100, 1'b0, 8'd44, 1'b1, 1'b0,
         1'b0, 1'b1);

      // Abort on the second RUN cycle, with a competing offer under reset.
      @(negedge clk);
      a = 8'd5;
      b = 8'd3;
      sb = 1'b0;
      iv[2] = 1'b1;
      @(posedge clk);
      #1 iv[2] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      iv[2] = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      iv[2] = 1'b0;
      chk1("abort.ov", ov[2], 1'b0);
      chk1("abort.in_ready", ir[2], 1'b1);
      chk8("abort.s", s2, 8'd0);
      chk1("abort.c", cc[2], 1'b0);
      chk1("abort.v", vv[2], 1'b0);
      chk1("abort.z", zz[2], 1'b0);
      for (int e = 0; e < 6; e++) begin
         @(posedge clk);
         #1 chk1("abort.no_result", ov[2], 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/seq_add_sub.md
# seq_add_sub

Parametrised, multi-cycle adder/subtractor that computes A+B or A−B on W-bit operands, CHUNK bits per clock, with a ripple carry held in a register between chunks. Operands enter and results leave through valid/ready handshakes, and the block reports carry/no-borrow, signed overflow and zero flags. It is the sequential, width-generic successor to our 4-bit combinational add/sub unit, and it sits between an operand source and a result consumer.

## Interface
Parameters:
- W, 8: operand and result width in bits; W ≥ 2.
- CHUNK, 4: bits processed per cycle. W % CHUNK must be 0; any other value is an elaboration error. N = W/CHUNK cycles per operation.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand offer.
- in_ready  out  1  block can accept operands.
- a  in  W  operand A, unsigned or two's complement.
- b  in  W  operand B.
- sub  in  1  0: A+B; 1: A−B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- s  out  W  sum or difference, modulo 2^W.
- c  out  1  carry out of the MSB. For subtraction, 1 means no borrow (A ≥ B unsigned).
- v  out  1  signed overflow.
- z  out  1  s == 0.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE, out_valid 0, s 0, c 0, v 0, z 0, chunk index 0, carry register 0.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational from state and out_ready.
- Accept happens on in_valid && in_ready:
  - latch a;
  - latch b XOR {W{sub}};
  - set the carry register to sub;
  - set the chunk index to 0;
  - go to RUN.
- RUN, each cycle:
  - chunk i = bits [i*CHUNK +: CHUNK] of the latched A and B;
  - add the chunk with carry-in = carry register;
  - write the chunk sum into bits [i*CHUNK +: CHUNK] of the result register;
  - carry register ← chunk carry out;
  - index i increments.
- Final chunk (i = N−1):
  - c ← carry out of the MSB;
  - v ← carry into the MSB XOR carry out of the MSB;
  - z ← (full result == 0);
  - out_valid ← 1;
  - go to DONE.
- s, c, v and z are updated only when out_valid rises. Intermediate chunk sums stay in an internal register, so s never shows partial results.
- DONE: out_valid is held high, and s, c, v, z are held stable until out_ready.
  - out_ready && !in_valid: go to IDLE, out_valid 0. s, c, v, z keep their values.
  - out_ready && in_valid: the result is consumed and new operands are accepted in the same cycle, then go directly to RUN (back-to-back).
- in_valid is ignored in RUN. a, b and sub are not sampled outside the accept cycle.

## Timing
- Latency: the accept edge at cycle k produces out_valid high after edge k+N. Chunks are processed on edges k+1 … k+N.
- CHUNK = W (N=1): out_valid is high one edge after accept.
- Throughput with back-to-back traffic and out_ready held high: one result per N+1 cycles.
- rst high on any edge, including mid-RUN or in DONE with out_valid high, overrides everything. The operation is aborted, reset values are applied, and in_ready reads 1 in the next cycle. The aborted result is never presented.
- Simultaneous rst and in_valid: reset wins and nothing is accepted.
- Wrap-around: s is modulo 2^W. c and v flag the wrap; there is no saturation.

## Structure
- Package seq_add_sub_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - function num_chunks(W, CHUNK).
- Sub-module chunk_adder (parameter CHUNK), combinational:
  - inputs: x, y, cin;
  - outputs: sum, cout, and c_msb_in (carry into its top bit, used for v on the last chunk).
- Top level holds the FSM, operand/result/carry registers, the chunk index counter, and the flag logic. The chunk index is $clog2(N) bits, minimum 1.

## Test plan
- W=4, CHUNK=2, a=6, b=6, sub=0 → out_valid 2 edges after accept; s=12 (4'b1100), c=0, v=1, z=0.
- W=4, CHUNK=2, sub=1:
  - 8−6 → s=2, c=1, v=1;
  - 10−6 → s=4, c=1, v=1;
  - 10−8 → s=2, c=1, v=0.
- W=8, CHUNK=4, 6−6 → s=0, c=1, v=0, z=1. 5−9 → s=252, c=0 (borrow), v=0.
- Backpressure and back-to-back:
  - hold out_ready=0 for 5 cycles → out_valid and s stay stable and in_ready=0;
  - then assert out_ready with in_valid=1 → new accept in the same cycle, and the next result appears N edges later.
- rst asserted on the second RUN cycle of W=8, CHUNK=2 → next cycle: state IDLE, out_valid=0, s=0, flags 0, in_ready=1. No result is produced afterwards.
- W=8, CHUNK=8 (N=1) and W=8, CHUNK=1 (N=8): 200+100 → s=44, c=1, v=0, with latency 1 and 8 edges respectively.
